instr_sequencer: RTL and testbench

Instruction fetch/issue controller that feeds `instructdecoder`. Fetches 18-bit instruction words from a synchronous program memory, presents each one on `id` with a one-cycle `id_valid` strobe, and stalls while the decoder reports a multi-cycle operation such as multiply. Handles `JMP` (PC reload) and `HALT` (stop fetching) locally. Sits between program memory and the decoder/datapath.

---
 rtl/instr_sequencer.sv | 109 ++++++++++
 tb/tb_instr_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer: fetches words from synchronous program memory,
// issues them to the decoder with a one-cycle strobe, and handles JMP/HALT locally.
module instr_sequencer #(
  parameter int          AW      = 8,
  parameter logic [3:0]  HALT_OP = 4'b1000,
  parameter logic [3:0]  JMP_OP  = 4'b1110
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [17:0]   imem_data,
  output logic [17:0]   id,
  output logic          id_valid,
  input  logic          dec_busy,
  output logic [AW-1:0] pc,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [17:0]     id_q, id_d;
  logic            id_valid_q, id_valid_d;
  logic            imem_rd_q, imem_rd_d;
  logic            halted_q, halted_d;
  logic [3:0]      opcode;

  assign opcode = id_q[17:14];

  // Strobes are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_d       = id_q;
    id_valid_d = 1'b0;
    imem_rd_d  = 1'b0;
    halted_d   = halted_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d      = '0;
          halted_d  = 1'b0;
          imem_rd_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        id_d       = imem_data;
        id_valid_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (opcode == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else if (opcode == JMP_OP) begin
          pc_d      = id_q[AW-1:0];
          imem_rd_d = 1'b1;
          state_d   = S_FETCH;
        end else if (!dec_busy) begin
          pc_d      = pc_q + AW'(1);
          imem_rd_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
      imem_rd_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
      imem_rd_q  <= imem_rd_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_rd   = imem_rd_q;
  assign imem_addr = pc_q;
  assign id        = id_q;
  assign id_valid  = id_valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a per-instruction timeline model.
module tb_instr_sequencer;

  localparam int         AW   = 8;
  localparam logic [3:0] HALT = 4'b1000;
  localparam logic [3:0] JMP  = 4'b1110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dec_busy = 1'b0;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [17:0]   imem_data = '0;
  logic [17:0]   id;
  logic          id_valid;
  logic [AW-1:0] pc;
  logic          halted;

  logic [17:0]   mem [0:255];
  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;

  int            fetch_q[$];
  int            fetch_cyc[$];
  logic [17:0]   issue_q[$];
  int            issue_cyc[$];

  instr_sequencer #(.AW(AW), .HALT_OP(HALT), .JMP_OP(JMP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_rd(imem_rd),
    .imem_addr(imem_addr), .imem_data(imem_data), .id(id),
    .id_valid(id_valid), .dec_busy(dec_busy), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  // Model: each instruction is tracked by its age since its fetch cycle
  // (0 = fetch, 1 = data returns, 2+ = issued and waiting on the decoder).
  bit          m_run, m_halted;
  logic [7:0]  m_pc;
  logic [17:0] m_id;
  int          m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_halted <= 1'b0; m_pc <= '0; m_id <= '0; m_age <= -1;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1; m_halted <= 1'b0; m_pc <= '0; m_age <= 0;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (m_age == 1) begin
      m_id <= mem[m_pc]; m_age <= 2;
    end else if (m_id[17:14] == HALT) begin
      m_run <= 1'b0; m_halted <= 1'b1; m_age <= -1;
    end else if (m_id[17:14] == JMP) begin
      m_pc <= m_id[7:0]; m_age <= 0;
    end else if (dec_busy) begin
      m_age <= m_age + 1;
    end else begin
      m_pc <= m_pc + 8'd1; m_age <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("imem_rd", 32'(imem_rd), 32'(m_run && m_age == 0));
    checkOutput("imem_addr", 32'(imem_addr), 32'(m_pc));
    checkOutput("pc", 32'(pc), 32'(m_pc));
    checkOutput("id", 32'(id), 32'(m_id));
    checkOutput("id_valid", 32'(id_valid), 32'(m_run && m_age == 2));
    checkOutput("halted", 32'(halted), 32'(m_halted));
  end

  task automatic tick();
    @(negedge clk);
    if (imem_rd) begin fetch_q.push_back(int'(imem_addr)); fetch_cyc.push_back(cycle); end
    if (id_valid) begin issue_q.push_back(id); issue_cyc.push_back(cycle); end
  endtask

  task automatic clearLog();
    fetch_q.delete(); fetch_cyc.delete(); issue_q.delete(); issue_cyc.delete();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0; start = 1'b0; dec_busy = 1'b0;
    runCycles(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulseStart(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cycle;
  endtask

  task automatic findFetch(input int addr, output int cyc);
    cyc = -1;
    for (int i = 0; i < fetch_q.size(); i++)
      if (fetch_q[i] == addr && cyc < 0) cyc = fetch_cyc[i];
  endtask

  task automatic waitValid(input string name, input int limit);
    int n = 0;
    while (!id_valid && n < limit) begin tick(); n++; end
    if (!id_valid) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [17:0] randWord(input bit allow_ctrl);
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (!allow_ctrl && (op == HALT || op == JMP || op == 4'b0100)) op = 4'b0010;
    return {op, 14'($urandom)};
  endfunction

  task automatic fillMem(input bit allow_ctrl);
    for (int a = 0; a < 256; a++) mem[a] = randWord(allow_ctrl);
  endtask

  // Runs a program from PC 0, holding dec_busy for busy_len cycles when busy_addr issues.
  task automatic applyStimulus(input int busy_addr, input int busy_len, input int n, output int s);
    int hold = 0;
    doReset();
    clearLog();
    pulseStart(s);
    for (int i = 0; i < n; i++) begin
      if (hold > 0) hold--;
      else if (id_valid && int'(pc) == busy_addr) hold = busy_len;
      dec_busy = (hold > 0);
      tick();
    end
    dec_busy = 1'b0;
  endtask

  initial begin
    int s, c0, c1, d0, d1, idx;

    fillMem(1'b0);
    doReset();
    checkOutput("rst_imem_rd", 32'(imem_rd), 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_id", 32'(id), 32'd0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);

    // Two-word program ending in HALT
    mem[0] = 18'b110010100011011000;
    mem[1] = 18'b100010111011001100;
    applyStimulus(-1, 0, 10, s);
    checkOutput("t1_n_issue", 32'(issue_q.size()), 32'd2);
    checkOutput("t1_n_fetch", 32'(fetch_q.size()), 32'd2);
    if (issue_q.size() >= 2 && fetch_q.size() >= 1) begin
      checkOutput("t1_word0", 32'(issue_q[0]), 32'h32_8D8);
      checkOutput("t1_word1", 32'(issue_q[1]), 32'h22_ECC);
      checkOutput("t1_interval", 32'(issue_cyc[1] - issue_cyc[0]), 32'd3);
      checkOutput("t1_first_fetch", 32'(fetch_cyc[0]), 32'(s));
      checkOutput("t1_first_issue", 32'(issue_cyc[0]), 32'(s + 2));
    end
    checkOutput("t1_halted", 32'(halted), 32'd1);
    checkOutput("t1_pc", 32'(pc), 32'd1);

    // Multiply stall at address 2, compared against the same program without a stall
    fillMem(1'b0);
    mem[2] = {4'b0100, 14'h0ABC};
    mem[3] = {HALT, 14'h0000};
    applyStimulus(-1, 0, 16, s);
    findFetch(3, c0);
    d0 = c0 - s;
    applyStimulus(2, 4, 20, s);
    findFetch(3, c1);
    d1 = c1 - s;
    checkOutput("t2_found", 32'(c0 >= 0 && c1 >= 0), 32'd1);
    checkOutput("t2_nostall_addr3", 32'(d0), 32'd9);
    checkOutput("t2_stall_delta", 32'(d1 - d0), 32'd4);
    checkOutput("t2_n_issue", 32'(issue_q.size()), 32'd4);

    // Jump from address 5 to 8'h10
    fillMem(1'b0);
    mem[5] = {JMP, 6'b0, 8'h10};
    mem[8'h10] = {HALT, 14'h0155};
    applyStimulus(-1, 0, 30, s);
    findFetch(6, c0);
    checkOutput("t3_no_addr6", 32'(c0), 32'hFFFF_FFFF);
    findFetch(5, c0);
    findFetch(8'h10, c1);
    checkOutput("t3_jmp_latency", 32'(c1 - c0), 32'd3);
    checkOutput("t3_pc", 32'(pc), 32'h10);
    checkOutput("t3_halted", 32'(halted), 32'd1);

    // PC wrap from 8'hFF
    fillMem(1'b0);
    mem[0] = {JMP, 6'b0, 8'hFF};
    mem[8'hFF] = {4'b0010, 14'h1234};
    applyStimulus(-1, 0, 8, s);
    checkOutput("t4_n_fetch", 32'(fetch_q.size()), 32'd3);
    if (fetch_q.size() >= 3) begin
      checkOutput("t4_fetch_ff", 32'(fetch_q[1]), 32'hFF);
      checkOutput("t4_wrap", 32'(fetch_q[2]), 32'h00);
      checkOutput("t4_wrap_gap", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd3);
    end

    // Asynchronous reset during a stall
    fillMem(1'b0);
    mem[0] = {4'b0100, 14'h3FFF};
    doReset();
    pulseStart(s);
    waitValid("t5", 10);
    dec_busy = 1'b1;
    runCycles(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rd", 32'(imem_rd), 32'd0);
    checkOutput("t5_pc", 32'(pc), 32'd0);
    checkOutput("t5_id", 32'(id), 32'd0);
    checkOutput("t5_valid", 32'(id_valid), 32'd0);
    checkOutput("t5_halted", 32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;
    dec_busy = 1'b0;
    clearLog();
    runCycles(8);
    checkOutput("t5_quiet_fetch", 32'(fetch_q.size()), 32'd0);
    checkOutput("t5_quiet_issue", 32'(issue_q.size()), 32'd0);

    // start ignored in WAIT; start restarts from HALTED
    mem[0] = {4'b0100, 14'h0001};
    mem[1] = {HALT, 14'h0002};
    doReset();
    pulseStart(s);
    waitValid("t6", 10);
    dec_busy = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("t6_pc_unchanged", 32'(pc), 32'd0);
    checkOutput("t6_no_fetch", 32'(imem_rd), 32'd0);
    dec_busy = 1'b0;
    runCycles(10);
    checkOutput("t6_halted", 32'(halted), 32'd1);
    checkOutput("t6_halt_pc", 32'(pc), 32'd1);
    pulseStart(s);
    checkOutput("t6_restart_halted", 32'(halted), 32'd0);
    checkOutput("t6_restart_pc", 32'(pc), 32'd0);
    checkOutput("t6_restart_rd", 32'(imem_rd), 32'd1);

    // Randomized programs, busy, start and resets
    fillMem(1'b1);
    doReset();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      dec_busy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1; start = 1'b0; dec_busy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
